// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: per-stage payload structs, their widths
// and their all-zero bubble constants, plus the occupancy counter width.
package pipeline_pkg;

    localparam int OCC_W = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1Val;
        logic [31:0] rs2Val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  aluOp;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
    } id_ex_t;

    typedef struct packed {
        logic [31:0] aluResult;
        logic [31:0] storeData;
        logic [4:0]  rd;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        regWrite;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    localparam if_id_t  IF_ID_BUBBLE  = '0;
    localparam id_ex_t  ID_EX_BUBBLE  = '0;
    localparam ex_mem_t EX_MEM_BUBBLE = '0;
    localparam mem_wb_t MEM_WB_BUBBLE = '0;

endpackage

// File: rtl/pipeline_slot.sv
// One payload register with a full flag.
// Ports: clock, reset (async, high), load, clear (wins over load),
// loadData in; full, data out (BUBBLE_VALUE whenever empty).
module pipeline_slot #(
    parameter int DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] loadData,
    output logic              full,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] held;

    // Clearing also scrubs the stored payload so nothing stale lingers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full <= 1'b0;
            held <= BUBBLE_VALUE;
        end else if (clear) begin
            full <= 1'b0;
            held <= BUBBLE_VALUE;
        end else if (load) begin
            full <= 1'b1;
            held <= loadData;
        end
    end

    assign data = full ? held : BUBBLE_VALUE;

endmodule

// File: rtl/pipeline_stage_register.sv
// Generic inter-stage register with valid/ready, stall, flush and bubble.
// Ports: clock, reset (async, high), flush, in_valid/in_ready/in_data,
// out_valid/out_ready/out_data, occupancy (held entries).
// Build option PIPE_SKID_EN adds a skid slot and a registered in_ready.
module pipeline_stage_register
    import pipeline_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter logic [DATA_W-1:0] BUBBLE_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy
);

    logic              mainFull;
    logic              mainLoad;
    logic              mainClear;
    logic [DATA_W-1:0] mainLoadData;
    logic              inXfer;
    logic              outXfer;

    assign inXfer  = in_valid && in_ready;
    assign outXfer = mainFull && out_ready;

    pipeline_slot #(
        .DATA_W       (DATA_W),
        .BUBBLE_VALUE (BUBBLE_VALUE)
    ) mainSlot (
        .clock    (clock),
        .reset    (reset),
        .load     (mainLoad),
        .clear    (mainClear),
        .loadData (mainLoadData),
        .full     (mainFull),
        .data     (out_data)
    );

    assign out_valid = mainFull;

`ifdef PIPE_SKID_EN

    logic              skidFull;
    logic              skidLoad;
    logic              skidClear;
    logic              skidFullNext;
    logic              inReadyReg;
    logic [DATA_W-1:0] skidData;

    pipeline_slot #(
        .DATA_W       (DATA_W),
        .BUBBLE_VALUE (BUBBLE_VALUE)
    ) skidSlot (
        .clock    (clock),
        .reset    (reset),
        .load     (skidLoad),
        .clear    (skidClear),
        .loadData (in_data),
        .full     (skidFull),
        .data     (skidData)
    );

    // A held skid beat is always older than the incoming one, so it
    // moves up first to keep arrival order.
    always_comb begin
        mainLoad     = 1'b0;
        mainClear    = 1'b0;
        skidLoad     = 1'b0;
        skidClear    = 1'b0;
        mainLoadData = skidFull ? skidData : in_data;
        if (flush) begin
            mainClear = 1'b1;
            skidClear = 1'b1;
        end else if (!mainFull || outXfer) begin
            if (skidFull) begin
                mainLoad  = 1'b1;
                skidLoad  = inXfer;
                skidClear = !inXfer;
            end else begin
                mainLoad  = inXfer;
                mainClear = !inXfer;
            end
        end else if (inXfer) begin
            skidLoad = 1'b1;
        end
    end

    assign skidFullNext = !skidClear && (skidLoad || skidFull);

    // Registered so in_ready never depends on out_ready combinationally.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inReadyReg <= 1'b0;
        end else begin
            inReadyReg <= !skidFullNext;
        end
    end

    assign in_ready  = inReadyReg;
    assign occupancy = {1'b0, mainFull} + {1'b0, skidFull};

`else

    always_comb begin
        mainLoad     = 1'b0;
        mainClear    = 1'b0;
        mainLoadData = in_data;
        if (flush) begin
            mainClear = 1'b1;
        end else if (!mainFull || outXfer) begin
            mainLoad  = inXfer;
            mainClear = !inXfer;
        end
    end

    assign in_ready  = !reset && (!mainFull || out_ready);
    assign occupancy = {1'b0, mainFull};

`endif

endmodule

// File: tb/tb_pipeline_stage_register.sv
// Self-checking bench for pipeline_stage_register against a queue model.
// Works in either build (with or without PIPE_SKID_EN).
module tb_pipeline_stage_register;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic [1:0]  occupancy;

    int passed = 0;
    int failed = 0;
    int total = 0;

    logic [63:0] q[$];
    logic        armed = 1'b0;
    logic        accepted;
    bit          seen55;

    pipeline_stage_register #(.DATA_W(64)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputs();
        logic [63:0] expData;
        expData = (q.size() > 0) ? q[0] : 64'd0;
        check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
        check("out_data", out_data, expData);
        check("occupancy", {62'd0, occupancy}, 64'(q.size()));
    endtask

    task automatic cycle(input logic v, input logic [63:0] d,
                         input logic ordy, input logic fl);
        logic expReady;
        logic outX;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
`ifdef PIPE_SKID_EN
        expReady = armed && (q.size() < 2);
`else
        expReady = (q.size() == 0) || ordy;
`endif
        check("in_ready", {63'd0, in_ready}, {63'd0, expReady});
        accepted = v && expReady;
        outX = (q.size() > 0) && ordy;
        @(posedge clock);
        #1;
        armed = 1'b1;
        if (fl) begin
            q.delete();
            accepted = 1'b0;
        end else begin
            if (outX) void'(q.pop_front());
            if (accepted) q.push_back(d);
        end
        checkOutputs();
        if (out_valid && out_data == 64'h55) seen55 = 1'b1;
    endtask

    initial begin
        seen55 = 1'b0;
        @(posedge clock);
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        checkOutputs();
        reset = 1'b0;
        #1;
        checkOutputs();

        cycle(1'b0, 64'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 64'(i), 1'b1, 1'b0);
        cycle(1'b0, 64'd0, 1'b1, 1'b0);

        cycle(1'b1, 64'hA, 1'b0, 1'b0);
        cycle(1'b1, 64'hB, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 64'hC, 1'b1, 1'b0);
            if (accepted) break;
        end
        check("c_accepted", {63'd0, accepted}, 64'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);

        cycle(1'b1, 64'h11, 1'b0, 1'b0);
        cycle(1'b1, 64'h22, 1'b0, 1'b0);
        cycle(1'b1, 64'h55, 1'b0, 1'b1);
        check("flush_empty", 64'(q.size()), 64'd0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);
        check("no_55", {63'd0, seen55}, 64'd0);

        cycle(1'b1, 64'h33, 1'b0, 1'b0);
        cycle(1'b1, 64'h44, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        q.delete();
        armed = 1'b0;
        check("mid_rst_in_ready", {63'd0, in_ready}, 64'd0);
        checkOutputs();
        @(posedge clock);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), {$urandom, $urandom},
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 19) == 0));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 64'd0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
